// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel-enable gated h/v counters with registered
// sync, blanking, display-enable and line/frame start pulses aligned to pixX/pixY.
module vga_sync_gen #(
  parameter int   H_ACTIVE  = 640,
  parameter int   H_FP      = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BP      = 48,
  parameter int   V_ACTIVE  = 480,
  parameter int   V_FP      = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BP      = 33,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0,
  parameter int   HW        = 10,
  parameter int   VW        = 10
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          pixEn,
  output logic          hsync,
  output logic          vsync,
  output logic          displayEn,
  output logic          vblank,
  output logic [HW-1:0] pixX,
  output logic [VW-1:0] pixY,
  output logic          lineStart,
  output logic          frameStart
);

  localparam int HTOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VTOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [HW-1:0] H_LAST = HW'(HTOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(VTOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] h_nxt;
  logic [VW-1:0] v_nxt;

  always_comb begin
    h_nxt = pixX;
    v_nxt = pixY;
    if (pixEn) begin
      if (pixX == H_LAST) begin
        h_nxt = '0;
        v_nxt = (pixY == V_LAST) ? '0 : pixY + VW'(1);
      end else begin
        h_nxt = pixX + HW'(1);
      end
    end
  end

  // Every output is decoded from the next counts so it lines up with pixX/pixY;
  // with pixEn low the next counts equal the current ones, so levels hold.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pixX       <= H_LAST;
      pixY       <= V_LAST;
      hsync      <= ~HSYNC_POL;
      vsync      <= ~VSYNC_POL;
      displayEn  <= 1'b0;
      vblank     <= 1'b1;
      lineStart  <= 1'b0;
      frameStart <= 1'b0;
    end else begin
      pixX       <= h_nxt;
      pixY       <= v_nxt;
      hsync      <= (h_nxt >= H_SS && h_nxt < H_SE) ? HSYNC_POL : ~HSYNC_POL;
      vsync      <= (v_nxt >= V_SS && v_nxt < V_SE) ? VSYNC_POL : ~VSYNC_POL;
      displayEn  <= (h_nxt < H_ACT) && (v_nxt < V_ACT);
      vblank     <= (v_nxt >= V_ACT);
      lineStart  <= pixEn && (h_nxt == '0);
      frameStart <= pixEn && (h_nxt == '0) && (v_nxt == '0);
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: default 640x480 timing for line-level checks, plus a tiny
// 16x12 raster (active-high hsync) for whole-frame, stall and pulse checks.
module tb_vga_sync_gen;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic pe = 1'b0, pe_s = 1'b0;
  always #5 clk = ~clk;

  logic       hs, vs, de, vb, ls, fs;
  logic [9:0] px, py;
  logic       hs_s, vs_s, de_s, vb_s, ls_s, fs_s;
  logic [3:0] px_s, py_s;

  int n_cmp = 0;
  int n_err = 0;

  vga_sync_gen dut (
    .clk(clk), .resetn(resetn), .pixEn(pe), .hsync(hs), .vsync(vs),
    .displayEn(de), .vblank(vb), .pixX(px), .pixY(py),
    .lineStart(ls), .frameStart(fs)
  );

  vga_sync_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b0), .HW(4), .VW(4)
  ) dut_s (
    .clk(clk), .resetn(resetn), .pixEn(pe_s), .hsync(hs_s), .vsync(vs_s),
    .displayEn(de_s), .vblank(vb_s), .pixX(px_s), .pixY(py_s),
    .lineStart(ls_s), .frameStart(fs_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic en, input logic en_s);
    @(negedge clk);
    pe = en;
    pe_s = en_s;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_big(input string tag, input int x, input int y, input logic h,
                         input logic v, input logic d, input logic b,
                         input logic l, input logic f);
    chk({tag, ".x"}, 32'(px), 32'(x));
    chk({tag, ".y"}, 32'(py), 32'(y));
    chk({tag, ".hs"}, 32'(hs), 32'(h));
    chk({tag, ".vs"}, 32'(vs), 32'(v));
    chk({tag, ".de"}, 32'(de), 32'(d));
    chk({tag, ".vb"}, 32'(vb), 32'(b));
    chk({tag, ".ls"}, 32'(ls), 32'(l));
    chk({tag, ".fs"}, 32'(fs), 32'(f));
  endtask

  task automatic chk_small(input string tag, input int x, input int y, input logic l,
                           input logic f);
    chk({tag, ".x"}, 32'(px_s), 32'(x));
    chk({tag, ".y"}, 32'(py_s), 32'(y));
    chk({tag, ".hs"}, 32'(hs_s), 32'(x >= 10 && x < 13));
    chk({tag, ".vs"}, 32'(vs_s), 32'(!(y >= 8 && y < 10)));
    chk({tag, ".de"}, 32'(de_s), 32'(x < 8 && y < 6));
    chk({tag, ".vb"}, 32'(vb_s), 32'(y >= 6));
    chk({tag, ".ls"}, 32'(ls_s), 32'(l));
    chk({tag, ".fs"}, 32'(fs_s), 32'(f));
  endtask

  initial begin
    int x, y, last_fs, n_fs, n_vfall, guard;
    logic en, vs_prev;

    // reset state on both instances
    step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    chk_big("rst", 799, 524, 1, 1, 0, 1, 0, 0);
    chk_small("rst_s", 15, 11, 0, 0);

    // first pixEn after reset lands on (0,0) with both pulses
    resetn = 1'b1;
    step(1'b1, 1'b0);
    chk_big("first", 0, 0, 1, 1, 1, 0, 1, 1);
    step(1'b0, 1'b0);
    chk_big("stall0", 0, 0, 1, 1, 1, 0, 0, 0);
    step(1'b1, 1'b0);
    chk_big("x1", 1, 0, 1, 1, 1, 0, 0, 0);

    // rest of line 0: hsync low 656..751, displayEn low from 640
    for (int i = 2; i < 800; i++) begin
      step(1'b1, 1'b0);
      chk("line.x", 32'(px), 32'(i));
      chk("line.hs", 32'(hs), 32'(!(i >= 656 && i < 752)));
      chk("line.de", 32'(de), 32'(i < 640));
      chk("line.ls", 32'(ls), 32'(0));
    end
    step(1'b1, 1'b0);
    chk_big("line1", 0, 1, 1, 1, 1, 0, 1, 0);

    // mid-frame reset with pixEn held high
    for (int i = 0; i < 300; i++) step(1'b1, 1'b0);
    chk("pre_rst.x", 32'(px), 32'(300));
    resetn = 1'b0;
    step(1'b1, 1'b0);
    chk_big("midrst", 799, 524, 1, 1, 0, 1, 0, 0);
    resetn = 1'b1;
    step(1'b1, 1'b0);
    chk_big("postrst", 0, 0, 1, 1, 1, 0, 1, 1);
    step(1'b0, 1'b0);

    // small raster, pixEn alternating: frame = 2*16*12 = 384 clocks
    x = 15; y = 11; last_fs = -1; n_fs = 0; n_vfall = 0; vs_prev = 1'b1;
    for (int i = 0; i < 1200; i++) begin
      en = (i % 2 == 0);
      step(1'b0, en);
      if (en) begin
        if (x == 15) begin
          x = 0;
          y = (y == 11) ? 0 : y + 1;
        end else x = x + 1;
      end
      chk_small("tog", x, y, en && x == 0, en && x == 0 && y == 0);
      if (fs_s) begin
        if (last_fs >= 0) chk("frame_len", 32'(i - last_fs), 32'(384));
        last_fs = i;
        n_fs++;
      end
      if (vs_prev && !vs_s) n_vfall++;
      vs_prev = vs_s;
    end
    chk("frame_cnt", 32'(n_fs), 32'(4));
    chk("vsync_falls", 32'(n_vfall), 32'(3));

    // small raster mid-frame reset at (5,7)
    guard = 0;
    while (!(x == 5 && y == 7) && guard < 400) begin
      step(1'b0, 1'b1);
      if (x == 15) begin
        x = 0;
        y = (y == 11) ? 0 : y + 1;
      end else x = x + 1;
      guard++;
    end
    chk("reach_5_7", 32'(guard < 400), 32'(1));
    chk_small("at_5_7", 5, 7, 0, 0);
    resetn = 1'b0;
    step(1'b0, 1'b1);
    chk_small("midrst_s", 15, 11, 0, 0);
    resetn = 1'b1;
    step(1'b0, 1'b1);
    chk_small("postrst_s", 0, 0, 1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
